board_input: RTL and testbench

//  Board-input side of the FPGA top: samples raw push-buttons and slide switches, synchronises and debounces

---
 rtl/board_input_pkg.sv | 20 ++
 rtl/debounce_bit.sv | 62 ++++++
 rtl/board_input.sv | 92 +++++++++
 tb/tb_board_input.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/board_input_pkg.sv
// ============================================================================
// board_input_pkg : register addresses and ID constant for the board-input
//                   read port.
// Revision        : 1.0
// ============================================================================
`default_nettype none

package board_input_pkg;

   localparam logic [1:0]  ADDR_SW  = 2'd0;
   localparam logic [1:0]  ADDR_BTN = 2'd1;
   localparam logic [1:0]  ADDR_EVT = 2'd2;
   localparam logic [1:0]  ADDR_ID  = 2'd3;

   // ASCII "INPT"
   localparam logic [31:0] ID_VALUE = 32'h494E_5054;

endpackage : board_input_pkg

`default_nettype wire

// File: rtl/debounce_bit.sv
// ============================================================================
// debounce_bit : 2-flop synchroniser plus hold-time debouncer for one pin,
//                with a single-cycle pulse on an accepted 0->1 change.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module debounce_bit #(
   parameter int DEB_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam int CNT_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d  = raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      rise     = 1'b0;
      // Any return to the accepted level restarts the hold window.
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
         rise     = sync2_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule : debounce_bit

`default_nettype wire

// File: rtl/board_input.sv
// ============================================================================
// board_input : debounced buttons/switches, sticky press flags with
//               read-to-clear, and a level interrupt for the core.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module board_input
   import board_input_pkg::*;
#(
   parameter int N_BTN   = 5,
   parameter int N_SW    = 16,
   parameter int DEB_CYC = 1_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_SW-1:0]  sw_raw,
   input  logic             rd_en,
   input  logic [1:0]       rd_addr,
   output logic [31:0]      rd_data,
   output logic             irq
);

   logic [N_BTN-1:0] btn_stable;
   logic [N_BTN-1:0] btn_rise;
   logic [N_SW-1:0]  sw_stable;
   logic [N_SW-1:0]  sw_rise_unused;

   logic [N_BTN-1:0] pending_q, pending_d;
   logic [N_BTN-1:0] clr_mask;
   logic [31:0]      rd_data_q, rd_data_d;
   logic             irq_q, irq_d;

   generate
      for (genvar i = 0; i < N_BTN; i++) begin : g_btn
         debounce_bit #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk    (clk),
            .rst    (rst),
            .raw    (btn_raw[i]),
            .stable (btn_stable[i]),
            .rise   (btn_rise[i])
         );
      end
      for (genvar j = 0; j < N_SW; j++) begin : g_sw
         debounce_bit #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk    (clk),
            .rst    (rst),
            .raw    (sw_raw[j]),
            .stable (sw_stable[j]),
            .rise   (sw_rise_unused[j])
         );
      end
   endgenerate

   always_comb begin
      clr_mask  = '0;
      rd_data_d = rd_data_q;
      if (rd_en) begin
         unique case (rd_addr)
            ADDR_SW:  rd_data_d = 32'(sw_stable);
            ADDR_BTN: rd_data_d = 32'(btn_stable);
            ADDR_EVT: begin
               rd_data_d = 32'(pending_q);
               clr_mask  = pending_q;
            end
            default:  rd_data_d = ID_VALUE;
         endcase
      end
      // A press landing on the clearing edge is kept for the next read.
      pending_d = (pending_q & ~clr_mask) | btn_rise;
      irq_d     = |pending_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         rd_data_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         rd_data_q <= rd_data_d;
         irq_q     <= irq_d;
      end
   end

   assign rd_data = rd_data_q;
   assign irq     = irq_q;

endmodule : board_input

`default_nettype wire

// File: tb/tb_board_input.sv
// ============================================================================
// tb_board_input : self-checking bench for board_input with DEB_CYC=4.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_board_input;
   import board_input_pkg::*;

   localparam int N_BTN   = 5;
   localparam int N_SW    = 16;
   localparam int DEB_CYC = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N_BTN-1:0] btn_raw = '0;
   logic [N_SW-1:0]  sw_raw  = '0;
   logic             rd_en   = 1'b0;
   logic [1:0]       rd_addr = 2'd0;
   logic [31:0]      rd_data;
   logic             irq;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } sb_item_t;

   sb_item_t sb_q[$];

   typedef struct {
      logic [N_SW-1:0]  sw;
      logic [N_BTN-1:0] btn;
      logic [1:0]       addr;
      logic [31:0]      exp;
      string            name;
   } vec_t;

   vec_t vecs[6];

   board_input #(
      .N_BTN   (N_BTN),
      .N_SW    (N_SW),
      .DEB_CYC (DEB_CYC)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_raw),
      .sw_raw  (sw_raw),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic tick(int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issue one read; the expected data is queued and checked by the monitor.
   task automatic rd(logic [1:0] addr, logic [31:0] exp, string name);
      sb_item_t it;
      it.exp  = exp;
      it.name = name;
      sb_q.push_back(it);
      rd_en   = 1'b1;
      rd_addr = addr;
      tick();
      rd_en   = 1'b0;
   endtask

   initial begin : monitor
      logic     en;
      sb_item_t it;
      forever begin
         @(posedge clk);
         en = rd_en;
         #1;
         if (en) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               it = sb_q.pop_front();
               check(it.name, rd_data, it.exp);
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: time limit reached, expected run to complete");
      $fatal(1, "timeout");
   end

   initial begin : stim
      vecs[0] = '{sw: 16'h0000, btn: 5'h00, addr: ADDR_ID,  exp: 32'h494E_5054, name: "map_id"};
      vecs[1] = '{sw: 16'hA5C3, btn: 5'h00, addr: ADDR_SW,  exp: 32'h0000_A5C3, name: "map_sw_a5c3"};
      vecs[2] = '{sw: 16'hFFFF, btn: 5'h00, addr: ADDR_SW,  exp: 32'h0000_FFFF, name: "map_sw_ffff"};
      vecs[3] = '{sw: 16'h0001, btn: 5'h1F, addr: ADDR_BTN, exp: 32'h0000_001F, name: "map_btn_1f"};
      vecs[4] = '{sw: 16'h8000, btn: 5'h10, addr: ADDR_SW,  exp: 32'h0000_8000, name: "map_sw_8000"};
      vecs[5] = '{sw: 16'h8000, btn: 5'h10, addr: ADDR_BTN, exp: 32'h0000_0010, name: "map_btn_10"};

      // Reset held with all buttons pressed.
      rst = 1'b1;
      btn_raw = 5'h1F;
      tick(3);
      check("reset_rd_data", rd_data, 32'h0);
      check("reset_irq", {31'd0, irq}, 32'h0);
      rst = 1'b0;
      for (int k = 0; k <= 6; k++)
         rd(ADDR_BTN, (k < 6) ? 32'h0 : 32'h1F, "reset_btn_latency");

      // Reset with flags pending discards them.
      rst = 1'b1;
      btn_raw = 5'h00;
      tick(2);
      rst = 1'b0;
      tick();
      rd(ADDR_EVT, 32'h0, "reset_discard_pending");
      check("reset_discard_irq", {31'd0, irq}, 32'h0);

      // Debounce latency and irq one cycle after the flag.
      btn_raw = 5'h01;
      for (int k = 0; k <= 6; k++) begin
         rd(ADDR_BTN, (k < 6) ? 32'h0 : 32'h1, "deb_btn0_latency");
         check("deb_irq_timing", {31'd0, irq}, (k >= 6) ? 32'h1 : 32'h0);
      end

      // Glitch rejection on a switch, then a just-long-enough pulse.
      sw_raw = 16'h0008;
      tick(3);
      sw_raw = 16'h0000;
      tick(8);
      rd(ADDR_SW, 32'h0, "glitch_3cyc");
      sw_raw = 16'h0008;
      tick(4);
      sw_raw = 16'h0000;
      tick(2);
      rd(ADDR_SW, 32'h8, "pulse_4cyc");
      tick(8);
      rd(ADDR_SW, 32'h0, "pulse_4cyc_release");

      // Read-clear of two pending flags.
      btn_raw = 5'h03;
      tick(8);
      rd(ADDR_EVT, 32'h3, "rdclr_first");
      check("rdclr_irq_held", {31'd0, irq}, 32'h1);
      rd(ADDR_EVT, 32'h0, "rdclr_second");
      check("rdclr_irq_drop", {31'd0, irq}, 32'h0);

      // Release generates no event; fresh press of btn0.
      btn_raw = 5'h00;
      tick(8);
      rd(ADDR_EVT, 32'h0, "release_no_event");
      btn_raw = 5'h01;
      tick(8);

      // btn2 acceptance lands on the same edge as the clear of btn0.
      btn_raw = 5'h05;
      tick(5);
      rd(ADDR_EVT, 32'h1, "collision_first");
      rd(ADDR_EVT, 32'h4, "collision_second");
      rd(ADDR_EVT, 32'h0, "collision_third");

      // Register map table.
      foreach (vecs[i]) begin
         sw_raw  = vecs[i].sw;
         btn_raw = vecs[i].btn;
         tick(8);
         rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
      end

      // rd_data holds its value while rd_en is low.
      tick(3);
      check("rd_data_hold", rd_data, 32'h0000_0010);

      tick(2);
      check("sb_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_board_input

`default_nettype wire
